// File: rtl/prog_ctrl_pkg.sv
// Shared definitions for the program run-control block.
//   run_state_t      : run-control FSM state encoding
//   START_ADDR       : program start address table, indexed by program select
//   prog_start_addr(): table lookup that falls back to program 0 for an
//                      out-of-range or unimplemented selection
package prog_ctrl_pkg;

  localparam int DEF_PC_W       = 10;
  localparam int DEF_CYC_W      = 16;
  localparam int NUM_START_ADDR = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RUN   = 3'd2,
    STALL = 3'd3,
    DONE  = 3'd4
  } run_state_t;

  localparam logic [DEF_PC_W-1:0] START_ADDR [NUM_START_ADDR] = '{10'd0, 10'd128, 10'd256};

  function automatic logic [DEF_PC_W-1:0] prog_start_addr(input logic [1:0] sel,
                                                          input int num_progs);
    logic [DEF_PC_W-1:0] addr;
    addr = START_ADDR[0];
    if (int'(sel) < num_progs) begin
      case (sel)
        2'd1:    addr = START_ADDR[1];
        2'd2:    addr = START_ADDR[2];
        default: addr = START_ADDR[0];
      endcase
    end
    return addr;
  endfunction

endpackage

// File: rtl/prog_run_ctrl_stall_timer.sv
// Loadable down-counter used to time PC freeze periods.
//   clk, rst_n  : clock, async active-low reset
//   i_load      : load i_load_val (wins over decrement)
//   i_load_val  : value to load
//   i_dec       : decrement by one, stops at zero
//   o_zero      : counter currently holds zero
module stall_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/prog_run_ctrl.sv
// Run-control sequencer for the program counter: start/run/done handshake,
// start-address load, and PC count gating for stalls, halt and watchdog.
//   Start/ProgSel        : arm while high, run begins on the falling edge
//   Halt/StallReq/StallLen : run-time controls sampled in RUN
//   CountEn/PcLoad/PcLoadAddr : PC controls
//   Ack/Timeout/RunCycles     : completion status and run length
//
// state | meaning
// IDLE  | post-reset, waiting for Start
// ARMED | Start high; PC held at selected start address
// RUN   | PC counting, run cycles accumulate
// STALL | PC frozen for the requested length, cycles still accumulate
// DONE  | halted or timed out; Ack held until next Start
module prog_run_ctrl
  import prog_ctrl_pkg::*;
#(
  parameter int          PC_W       = DEF_PC_W,
  parameter int          NUM_PROGS  = 3,
  parameter int          CYC_W      = DEF_CYC_W,
  parameter int          STALL_W    = 3,
  parameter int unsigned MAX_CYCLES = 32'h0000_FFF0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Start,
  input  logic [1:0]         ProgSel,
  input  logic               Halt,
  input  logic               StallReq,
  input  logic [STALL_W-1:0] StallLen,
  output logic               CountEn,
  output logic               PcLoad,
  output logic [PC_W-1:0]    PcLoadAddr,
  output logic               Ack,
  output logic               Timeout,
  output logic [CYC_W-1:0]   RunCycles
);

  localparam logic [CYC_W-1:0] WDOG_LAST = CYC_W'(MAX_CYCLES - 1);

  run_state_t         r_state;
  run_state_t         w_state_nxt;
  logic               w_stall_load;
  logic               w_wdog_stop;
  logic               w_wdog;
  logic               w_stall_zero;
  logic [STALL_W-1:0] w_stall_val;
  logic [PC_W-1:0]    r_addr;
  logic [CYC_W-1:0]   r_cycles;
  logic               r_timeout;

  // A zero length still freezes for one cycle.
  assign w_stall_val = (StallLen == '0) ? '0 : StallLen - STALL_W'(1);
  assign w_wdog      = (r_cycles >= WDOG_LAST);

  stall_timer #(.W(STALL_W)) u_stall_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_stall_load),
    .i_load_val (w_stall_val),
    .i_dec      (r_state == STALL),
    .o_zero     (w_stall_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_stall_load = 1'b0;
    w_wdog_stop  = 1'b0;
    case (r_state)
      IDLE:  if (Start) w_state_nxt = ARMED;
      ARMED: if (!Start) w_state_nxt = RUN;
      RUN: begin
        if (Start) begin
          w_state_nxt = ARMED;
        end else if (Halt) begin
          w_state_nxt = DONE;
        end else if (w_wdog) begin
          w_state_nxt = DONE;
          w_wdog_stop = 1'b1;
        end else if (StallReq) begin
          w_state_nxt  = STALL;
          w_stall_load = 1'b1;
        end
      end
      STALL: begin
        if (Start) begin
          w_state_nxt = ARMED;
        end else if (w_wdog) begin
          w_state_nxt = DONE;
          w_wdog_stop = 1'b1;
        end else if (w_stall_zero) begin
          w_state_nxt = RUN;
        end
      end
      DONE:    if (Start) w_state_nxt = ARMED;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    CountEn = (r_state == RUN);
    PcLoad  = (r_state == ARMED);
    Ack     = (r_state == DONE);
  end

  // Entering or staying in ARMED resamples the address and clears the
  // previous run's status; IDLE is only reachable by reset, so r_addr is
  // already zero there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_cycles  <= '0;
      r_timeout <= 1'b0;
    end else if (w_state_nxt == ARMED) begin
      r_addr    <= PC_W'(prog_start_addr(ProgSel, NUM_PROGS));
      r_cycles  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if ((r_state == RUN) || (r_state == STALL))
        r_cycles <= (&r_cycles) ? r_cycles : r_cycles + CYC_W'(1);
      if (w_wdog_stop)
        r_timeout <= 1'b1;
    end
  end

  assign PcLoadAddr = r_addr;
  assign Timeout    = r_timeout;
  assign RunCycles  = r_cycles;

endmodule
